// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front-end.
//   state_t / BOOT..DRAIN : 2-bit FSM encoding, kept identical to the cu_state debug width
//   level_width()         : width of an occupancy counter able to hold 0..depth
package fetch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t BOOT  = 2'b00;
  localparam state_t FETCH = 2'b01;
  localparam state_t STALL = 2'b10;
  localparam state_t DRAIN = 2'b11;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Flash read port plus instruction handshake of the fetch unit.
//   flash_rd_en/flash_addr  : read request, held until flash_ready
//   flash_data/flash_ready  : read data, valid when flash_rd_en && flash_ready
//   instr_valid/instr_ready : instruction handshake towards the control unit
//   instr/instr_pc          : assembled instruction (first word in LSBs) and its address
// master = fetch unit side, slave = flash + control unit side.
interface fetch_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int INSTR_WORDS = 2
);
  logic                              flash_rd_en;
  logic [ADDR_WIDTH-1:0]             flash_addr;
  logic [DATA_WIDTH-1:0]             flash_data;
  logic                              flash_ready;
  logic                              instr_valid;
  logic                              instr_ready;
  logic [DATA_WIDTH*INSTR_WORDS-1:0] instr;
  logic [ADDR_WIDTH-1:0]             instr_pc;

  modport master (
    output flash_rd_en, flash_addr, instr_valid, instr, instr_pc,
    input  flash_data, flash_ready, instr_ready
  );

  modport slave (
    input  flash_rd_en, flash_addr, instr_valid, instr, instr_pc,
    output flash_data, flash_ready, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding whole instructions.
//   clk, arst_n        : clock, asynchronous active-low reset
//   clr                : synchronous flush (empties the FIFO, wins over push/pop)
//   push, push_data    : write one entry (ignored when full)
//   pop                : remove head entry (ignored when empty)
//   head_data, empty   : head entry and empty flag
//   level              : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo import fetch_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
)(
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          clr,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_data,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (level == '0);
  assign do_push   = push && (level != LVL_W'(DEPTH));
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[PTR_W'(i)] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end.
//   clk, arst_n   : clock, asynchronous active-low reset
//   bus           : flash read port + instruction handshake (fetch_if.master)
//   pc_load       : branch; flush and refetch from pc_next
//   pc_next       : branch target
//   bootstrapping : high until flash reports initialised
//   fifo_level    : buffered instruction count (debug)
module fetch_unit import fetch_pkg::*; #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int INSTR_WORDS  = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int RESET_VECTOR = 0
)(
  input  logic                               clk,
  input  logic                               arst_n,
  fetch_if.master                            bus,
  input  logic                               pc_load,
  input  logic [ADDR_WIDTH-1:0]              pc_next,
  output logic                               bootstrapping,
  output logic [level_width(FIFO_DEPTH)-1:0] fifo_level
);
  localparam int IW    = DATA_WIDTH * INSTR_WORDS;
  localparam int IDX_W = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
  localparam int LVL_W = level_width(FIFO_DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(INSTR_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] RST_PC   = ADDR_WIDTH'(RESET_VECTOR);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IW-1:0]         asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] start_pc_q, start_pc_d;

  logic                       push, pop, clr, fifo_empty;
  logic [IW-1:0]              push_instr;
  logic [ADDR_WIDTH-1:0]      push_pc;
  logic [LVL_W-1:0]           level_after;
  logic [IW+ADDR_WIDTH-1:0]   head;

  assign bus.flash_rd_en = rd_en_q;
  assign bus.flash_addr  = addr_q;
  assign bootstrapping   = (state_q == BOOT);
  assign pop             = bus.instr_valid && bus.instr_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rd_en_d     = rd_en_q;
    addr_d      = addr_q;
    tgt_d       = tgt_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    start_pc_d  = start_pc_q;
    push        = 1'b0;
    clr         = 1'b0;
    level_after = fifo_level;
    // Incoming word merged into its slot so the last word can be pushed
    // in the same cycle it arrives.
    push_instr  = asm_q;
    push_instr[idx_q*DATA_WIDTH +: DATA_WIDTH] = bus.flash_data;
    push_pc     = (idx_q == '0) ? pc_q : start_pc_q;

    case (state_q)
      BOOT: begin
        if (pc_load) pc_d = pc_next;
        if (bus.flash_ready) begin
          state_d = FETCH;
          rd_en_d = 1'b1;
          addr_d  = pc_load ? pc_next : pc_q;
        end
      end
      FETCH, STALL: begin
        if (pc_load) begin
          clr   = 1'b1;
          idx_d = '0;
          asm_d = '0;
          if (rd_en_q && !bus.flash_ready) begin
            // Open request must complete before the new address goes out.
            state_d = DRAIN;
            tgt_d   = pc_next;
          end else begin
            state_d = FETCH;
            pc_d    = pc_next;
            rd_en_d = 1'b1;
            addr_d  = pc_next;
          end
        end else if (!(rd_en_q && !bus.flash_ready)) begin
          if (rd_en_q) begin
            pc_d  = pc_q + ADDR_WIDTH'(1);
            asm_d = push_instr;
            if (idx_q == '0) start_pc_d = pc_q;
            if (idx_q == LAST_IDX) begin
              push  = 1'b1;
              idx_d = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          // Next request only if the FIFO will still have room; at most one
          // instruction is ever in assembly, so this cannot overflow.
          level_after = fifo_level + LVL_W'(push) - LVL_W'(pop);
          rd_en_d     = (level_after < LVL_W'(FIFO_DEPTH));
          addr_d      = pc_d;
          state_d     = rd_en_d ? FETCH : STALL;
        end
      end
      DRAIN: begin
        clr = pc_load;
        if (pc_load) tgt_d = pc_next;
        if (bus.flash_ready) begin
          state_d = FETCH;
          pc_d    = pc_load ? pc_next : tgt_q;
          rd_en_d = 1'b1;
          addr_d  = pc_d;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= BOOT;
      pc_q       <= RST_PC;
      rd_en_q    <= 1'b0;
      addr_q     <= RST_PC;
      tgt_q      <= RST_PC;
      idx_q      <= '0;
      asm_q      <= '0;
      start_pc_q <= RST_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      tgt_q      <= tgt_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      start_pc_q <= start_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH(IW + ADDR_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .clr       (clr),
    .push      (push),
    .push_data ({push_instr, push_pc}),
    .pop       (pop),
    .head_data (head),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = head[ADDR_WIDTH +: IW];
  assign bus.instr_pc    = head[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        fr = 1'b0;
  logic        ir = 1'b0;
  logic        pc_load = 1'b0;
  logic [11:0] pc_next = '0;
  logic        bootstrapping;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int a0;

  // model state
  logic [11:0] exp_pc = '0;
  bit          booted = 1'b0;
  bit          prev_open = 1'b0;
  bit          prev_load = 1'b0;
  logic [11:0] prev_addr = '0;

  fetch_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .INSTR_WORDS(2)) bus ();

  // flash: always returns the low byte of the requested address
  assign bus.flash_ready = fr;
  assign bus.flash_data  = bus.flash_addr[7:0];
  assign bus.instr_ready = ir;

  fetch_unit #(
    .ADDR_WIDTH(12), .DATA_WIDTH(8), .INSTR_WORDS(2), .FIFO_DEPTH(4), .RESET_VECTOR(0)
  ) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus), .pc_load(pc_load), .pc_next(pc_next),
    .bootstrapping(bootstrapping), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_instr(input logic [11:0] pc);
    logic [11:0] p1;
    p1 = pc + 12'd1;
    return {p1[7:0], pc[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n;
    n = 0;
    while (!bus.instr_valid && n < max_cycles) begin
      tick();
      n++;
    end
    if (!bus.instr_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  // Continuous compare: instruction stream, request hold, flush, boot flag.
  always @(negedge clk) begin
    if (!arst_n) begin
      exp_pc    = '0;
      booted    = 1'b0;
      prev_open = 1'b0;
      prev_load = 1'b0;
    end else begin
      chk("bootstrapping", {31'd0, bootstrapping}, {31'd0, !booted});
      if (fr) booted = 1'b1;
      if (prev_open) begin
        chk("hold_rd_en", {31'd0, bus.flash_rd_en}, 32'd1);
        chk("hold_addr", {20'd0, bus.flash_addr}, {20'd0, prev_addr});
      end
      prev_open = bus.flash_rd_en && !fr;
      prev_addr = bus.flash_addr;
      if (bus.flash_rd_en && fr) accepts++;
      chk("rd_en_room", {31'd0, bus.flash_rd_en && (fifo_level >= 3'd4)}, 32'd0);
      if (prev_load) chk("flush_valid", {31'd0, bus.instr_valid}, 32'd0);
      prev_load = pc_load;
      if (bus.instr_valid && ir) begin
        chk("sb_instr", {16'd0, bus.instr}, {16'd0, exp_instr(exp_pc)});
        chk("sb_pc", {20'd0, bus.instr_pc}, {20'd0, exp_pc});
        exp_pc = exp_pc + 12'd2;
      end
      if (pc_load) exp_pc = pc_next;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    #2;
    chk("rst_rd_en", {31'd0, bus.flash_rd_en}, 32'd0);
    chk("rst_addr", {20'd0, bus.flash_addr}, 32'h000);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, bus.instr}, 32'h0000);
    chk("rst_pc", {20'd0, bus.instr_pc}, 32'h000);
    chk("rst_boot", {31'd0, bootstrapping}, 32'd1);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    repeat (2) tick();
    arst_n = 1'b1;
    ir = 1'b1;

    // boot wait
    repeat (10) begin
      tick();
      chk("boot_hold", {31'd0, bootstrapping}, 32'd1);
      chk("boot_no_req", {31'd0, bus.flash_rd_en}, 32'd0);
    end
    fr = 1'b1;
    tick();
    chk("boot_done", {31'd0, bootstrapping}, 32'd0);
    chk("first_req", {31'd0, bus.flash_rd_en}, 32'd1);
    chk("first_addr", {20'd0, bus.flash_addr}, 32'h000);

    // zero-wait stream, one instruction every two cycles
    tick(); chk("s_v1", {31'd0, bus.instr_valid}, 32'd0);
    tick(); chk("s_v2", {31'd0, bus.instr_valid}, 32'd1);
    chk("s_i0", {16'd0, bus.instr}, 32'h0100);
    chk("s_p0", {20'd0, bus.instr_pc}, 32'h000);
    tick(); chk("s_v3", {31'd0, bus.instr_valid}, 32'd0);
    tick(); chk("s_v4", {31'd0, bus.instr_valid}, 32'd1);
    chk("s_i1", {16'd0, bus.instr}, 32'h0302);
    chk("s_p1", {20'd0, bus.instr_pc}, 32'h002);

    // backpressure
    ir = 1'b0;
    repeat (12) tick();
    chk("bp_level", {29'd0, fifo_level}, 32'd4);
    chk("bp_rd_en", {31'd0, bus.flash_rd_en}, 32'd0);
    ir = 1'b1;
    tick();
    ir = 1'b0;
    a0 = accepts;
    chk("bp_pop_level", {29'd0, fifo_level}, 32'd3);
    chk("bp_pop_rd_en", {31'd0, bus.flash_rd_en}, 32'd1);
    repeat (8) tick();
    chk("bp_one_more", a0 + 2, accepts);
    chk("bp_level2", {29'd0, fifo_level}, 32'd4);
    chk("bp_rd_en2", {31'd0, bus.flash_rd_en}, 32'd0);

    // branch, then branch again while a request is open at 0x005
    ir = 1'b1;
    pc_load = 1'b1; pc_next = 12'h004;
    tick();
    pc_load = 1'b0;
    chk("br_req", {31'd0, bus.flash_rd_en}, 32'd1);
    chk("br_addr", {20'd0, bus.flash_addr}, 32'h004);
    chk("br_valid", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    chk("br_addr5", {20'd0, bus.flash_addr}, 32'h005);
    fr = 1'b0;
    repeat (2) tick();
    pc_load = 1'b1; pc_next = 12'h080;
    tick();
    pc_load = 1'b0;
    repeat (3) tick();
    chk("dr_addr", {20'd0, bus.flash_addr}, 32'h005);
    chk("dr_rd_en", {31'd0, bus.flash_rd_en}, 32'd1);
    chk("dr_valid", {31'd0, bus.instr_valid}, 32'd0);
    fr = 1'b1;
    tick();
    chk("dr_new_addr", {20'd0, bus.flash_addr}, 32'h080);
    chk("dr_new_req", {31'd0, bus.flash_rd_en}, 32'd1);
    wait_valid(10);
    chk("dr_pc", {20'd0, bus.instr_pc}, 32'h080);
    chk("dr_instr", {16'd0, bus.instr}, 32'h8180);
    repeat (3) tick();

    // wrap across 0xFFF, latency from pc_load
    pc_load = 1'b1; pc_next = 12'hFFF;
    tick();
    pc_load = 1'b0;
    chk("wr_v1", {31'd0, bus.instr_valid}, 32'd0);
    chk("wr_addr", {20'd0, bus.flash_addr}, 32'hFFF);
    chk("wr_req", {31'd0, bus.flash_rd_en}, 32'd1);
    tick(); chk("wr_v2", {31'd0, bus.instr_valid}, 32'd0);
    tick(); chk("wr_v3", {31'd0, bus.instr_valid}, 32'd1);
    chk("wr_instr", {16'd0, bus.instr}, 32'h00FF);
    chk("wr_pc", {20'd0, bus.instr_pc}, 32'hFFF);
    tick();
    wait_valid(10);
    chk("wr_next_pc", {20'd0, bus.instr_pc}, 32'h001);
    chk("wr_next_instr", {16'd0, bus.instr}, 32'h0201);

    // reset mid-FETCH with three buffered instructions
    ir = 1'b0;
    begin
      int n;
      n = 0;
      while (fifo_level != 3'd3 && n < 20) begin
        tick();
        n++;
      end
      chk("pre_rst_level", {29'd0, fifo_level}, 32'd3);
    end
    arst_n = 1'b0;
    fr = 1'b0;
    #1;
    chk("mrst_rd_en", {31'd0, bus.flash_rd_en}, 32'd0);
    chk("mrst_addr", {20'd0, bus.flash_addr}, 32'h000);
    chk("mrst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("mrst_instr", {16'd0, bus.instr}, 32'h0000);
    chk("mrst_pc", {20'd0, bus.instr_pc}, 32'h000);
    chk("mrst_boot", {31'd0, bootstrapping}, 32'd1);
    chk("mrst_level", {29'd0, fifo_level}, 32'd0);
    repeat (2) tick();
    arst_n = 1'b1;
    ir = 1'b1;
    tick();
    fr = 1'b1;
    tick();
    wait_valid(10);
    chk("reboot_pc", {20'd0, bus.instr_pc}, 32'h000);
    chk("reboot_instr", {16'd0, bus.instr}, 32'h0100);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction fetch front-end for the next-generation microcontroller core. It replaces the fixed 8-bit PC and flash-address path.
- Waits out flash bootstrap after reset.
- Streams words from a request/ready flash port.
- Assembles INSTR_WORDS words per instruction and buffers whole instructions in a prefetch FIFO.
- Hands instructions to the control unit over a valid/ready handshake.
- Flushes on branch (pc_load).

Parameters:
ADDR_WIDTH, 12, flash word address width; PC wraps modulo 2^ADDR_WIDTH
DATA_WIDTH, 8, flash word width
INSTR_WORDS, 2, flash words per instruction (>=1)
FIFO_DEPTH, 4, prefetch entries (power of 2, >=2)
RESET_VECTOR, 0, first fetch address after boot

Ports:
clk  in  1  clock, rising edge
arst_n  in  1  asynchronous active-low reset
flash_rd_en  out  1  read request; held with flash_addr until flash_ready
flash_addr  out  ADDR_WIDTH  word address of request
flash_data  in  DATA_WIDTH  read data, valid when flash_rd_en && flash_ready
flash_ready  in  1  request accepted/data valid; before boot, high = flash initialised
pc_load  in  1  branch: flush and refetch from pc_next
pc_next  in  ADDR_WIDTH  branch target
instr_valid  out  1  instr/instr_pc valid
instr_ready  in  1  consumer accepts instruction
instr  out  DATA_WIDTH*INSTR_WORDS  instruction; first fetched word in LSBs
instr_pc  out  ADDR_WIDTH  address of instruction's first word
bootstrapping  out  1  high until flash initialised
fifo_level  out  clog2(FIFO_DEPTH)+1  buffered instruction count (debug)

Behaviour:
- Reset (async, arst_n=0) values:
  - flash_rd_en=0, flash_addr=RESET_VECTOR, instr_valid=0, instr=0, instr_pc=0.
  - bootstrapping=1, fifo_level=0; FSM in BOOT; PC=RESET_VECTOR.
  - Reset mid-transaction drops the request immediately; no completion is owed.
- FSM states:
  - BOOT: flash_rd_en=0. Go to FETCH on the first cycle flash_ready=1; bootstrapping falls the same edge.
  - FETCH: flash_rd_en=1 while fifo_level<FIFO_DEPTH. When flash_rd_en && flash_ready:
    - capture the word into assembler slot word_idx;
    - PC<=PC+1 (wraps);
    - word_idx increments.
    - On the last word (word_idx=INSTR_WORDS-1), push {assembled, start_pc} into the FIFO and reset word_idx.
  - STALL: entered when fifo_level=FIFO_DEPTH with no request open; flash_rd_en=0; return to FETCH when a pop frees space.
  - DRAIN: pc_load arrived while a request was open (flash_rd_en=1, not yet ready). Keep flash_rd_en and flash_addr unchanged until flash_ready, then discard the data and go to FETCH at the latched target.
- Request rules:
  - flash_addr and flash_rd_en are registered.
  - flash_addr never changes while flash_rd_en=1 && flash_ready=0.
  - Back-to-back requests are allowed: zero-wait flash yields 1 word/cycle.
- Flush (pc_load=1 in cycle t):
  - FIFO emptied; assembler and word_idx cleared; PC<=pc_next (or latched for DRAIN).
  - instr_valid=0 from t+1.
  - A flash response in cycle t is discarded.
  - An instr handshake in cycle t is honoured (pop counts) before the flush.
  - pc_load during BOOT: update PC only; stay in BOOT.
- Latency: pc_load at t with zero-wait flash and no open request:
  - flash_rd_en=1 at t+1;
  - instr_valid=1 at t+1+INSTR_WORDS.
- FIFO:
  - Push and pop in the same cycle: level unchanged.
  - Pop only when instr_valid && instr_ready.
  - Output registered from the head; never overflows, because a request is issued only while level<FIFO_DEPTH and one instruction at most is in assembly.
- Arithmetic: PC is unsigned ADDR_WIDTH, wraps from all-ones to 0 mid-instruction without error.

Decomposition:
- Shared package fetch_pkg:
  - FSM state encoding: BOOT=2'b00, FETCH=2'b01, STALL=2'b10, DRAIN=2'b11 (matches existing 2-bit cu_state debug width);
  - helper function for the level width.
- One sub-module fetch_fifo: parametrised by WIDTH=DATA_WIDTH*INSTR_WORDS+ADDR_WIDTH and DEPTH; synchronous clear input used for flush.

Test Plan:
- Boot: flash_ready=0 for 10 cycles, then 1 → bootstrapping drops that edge; first flash_rd_en next cycle with flash_addr=0x000.
- Stream, zero-wait, flash words = low byte of address, instr_ready=1 → instr=0x0100 pc=0x000, then 0x0302 pc=0x002, one instruction every 2 cycles.
- Backpressure: instr_ready=0 → fifo_level reaches 4, flash_rd_en drops; one pop → exactly one more instruction fetched.
- Branch with open request: flash stalls at addr 0x005, pc_load pc_next=0x080 → addr 0x005 held until ready, data discarded, next request 0x080, first instr_pc=0x080.
- Wrap: pc_load pc_next=0xFFF → instr={word@0x000, word@0xFFF}, instr_pc=0xFFF, next instr_pc=0x001.
- Reset asserted mid-FETCH with level=3 → all outputs at reset values immediately; bootstrapping=1.
